anabellek_denetleyici: RTL and testbench
========================================

# anabellek_denetleyici

Main-memory controller serving 128-bit block requests from the instruction and data caches. A client hands over a block-aligned address; the block moves to or from a 32-bit word-wide memory backend in four sequential beats. For reads, the assembled 128-bit block is returned with a one-cycle `hazir_o` pulse. Sits between the cache wrappers (instruction-cache fill path, data-cache fill/writeback) and the physical memory port.

## Interface

- no parameters (block width 128, word width 32, beats 4 are fixed)
- `clk_i` in 1: single clock, all logic on rising edge
- `rst_i` in 1: asynchronous, active-low reset
- `istek_i` in 1: client request; sampled only while `musait_o`=1
- `oku_i` in 1: read request qualifier
- `yaz_i` in 1: write request; has priority over `oku_i`
- `adres_i` in 32: request byte address; bits [3:0] ignored
- `yaz_obek_i` in 128: write block, latched at acceptance
- `musait_o` out 1: controller idle, can accept a request
- `hazir_o` out 1: one-cycle completion pulse
- `obek_o` out 128: last read block; valid while `hazir_o`=1 and held until next read completes
- `bellek_istek_o` out 1: backend beat request
- `bellek_yaz_o` out 1: backend beat is a write
- `bellek_adres_o` out 32: backend word address (byte address, word-aligned)
- `bellek_veri_o` out 32: backend write data
- `bellek_veri_i` in 32: backend read data, valid with `bellek_gecerli_i`
- `bellek_gecerli_i` in 1: backend beat complete (read data valid / write accepted)

## Operation

- States: BOSTA, AKTAR, TAMAM. Two-bit beat counter `sayac` (0..3).
- BOSTA: `musait_o`=1. On edge where `istek_i`=1: latch `taban = {adres_i[31:4],4'b0}`, `yaz = yaz_i`, latch `yaz_obek_i`, `sayac`<=0, go AKTAR. `oku_i`=`yaz_i`=0 with `istek_i`=1 is treated as a read.
- AKTAR: `bellek_istek_o`=1, `bellek_adres_o = taban + 4*sayac`, `bellek_yaz_o = yaz`, `bellek_veri_o` = write word `sayac` (bits [32*sayac+31 : 32*sayac]). Address/data stay stable until `bellek_gecerli_i`=1.
  - On `bellek_gecerli_i`=1, read: store `bellek_veri_i` into block bits [32*sayac+31 : 32*sayac] (byte n of block at bits [8n+7:8n]). Increment `sayac`; if `sayac`=3, go TAMAM.
  - `bellek_gecerli_i` outside AKTAR is ignored.
- TAMAM: `hazir_o`=1 for exactly one cycle. For reads, `obek_o` presents the assembled block in this cycle. Then go BOSTA. Writes pulse `hazir_o` too; `obek_o` is unchanged.
- `istek_i`, `adres_i`, `oku_i`, `yaz_i` are don't-care after acceptance. The transaction always completes, even if the client drops its request (cache stall).
- No aborts and no timeouts. The backend must eventually raise `bellek_gecerli_i`.

## Timing

- Reset (async assert): state BOSTA, `sayac`=0, `obek_o`=0, `hazir_o`=0, `bellek_istek_o`=0, `bellek_yaz_o`=0, `bellek_adres_o`=0, `bellek_veri_o`=0. `musait_o`=0 while `rst_i`=0; it becomes 1 on the first rising edge after release.
- Reset mid-transaction: returns to BOSTA immediately. The partial block is discarded, and no `hazir_o` is issued.
- All outputs are registered or decoded from registered state only. No combinational path from `istek_i` or `bellek_gecerli_i` to any output.
- `musait_o` falls at the acceptance edge and rises at the edge leaving TAMAM. A new request may be accepted in the cycle `musait_o` is high again, giving back-to-back blocks with one idle cycle.
- Zero-wait backend (`gecerli` same cycle as `istek`): acceptance edge T; beats in cycles T+1..T+4; `hazir_o` in cycle T+5. Each backend wait cycle adds one cycle.
- Beat address wraps within the block: it is never carried out of bits [3:2].

## Test plan

- Zero-wait read: backend returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 for 0x1000, 0x1004, 0x1008, 0x100C. Request `adres_i`=0x1007 -> backend addresses 0x1000..0x100C; `hazir_o` 5 cycles after acceptance; `obek_o`=0x44444444_33333333_22222222_11111111.
- Wait states: 2 wait cycles per beat -> `bellek_adres_o` stable while waiting; `hazir_o` 13 cycles after acceptance; same data.
- Write: `yaz_i`=`oku_i`=1, `yaz_obek_i`=0xDDDD…_AAAA… -> `bellek_yaz_o`=1 on all beats; `bellek_veri_o` sequence 0xAAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD; `hazir_o` pulses; `obek_o` unchanged.
- Request dropped: `istek_i` deasserted one cycle after acceptance -> all 4 beats still occur and `hazir_o` pulses once.
- Back-to-back: `istek_i` held high for 0x2000 then 0x3000 -> second accepted exactly when `musait_o` returns; addresses never interleave.
- Reset in beat 2 -> `bellek_istek_o`=0 immediately, no `hazir_o`. After release, `musait_o`=1 after one edge, and a fresh read completes normally.

Source files
------------

// File: rtl/anabellek_denetleyici.sv
// Main-memory controller: moves one 128-bit block to or from a 32-bit backend
// in four sequential beats, with a single-cycle completion pulse per block.
module anabellek_denetleyici (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         istek_i,
  input  logic         oku_i,
  input  logic         yaz_i,
  input  logic [31:0]  adres_i,
  input  logic [127:0] yaz_obek_i,
  output logic         musait_o,
  output logic         hazir_o,
  output logic [127:0] obek_o,
  output logic         bellek_istek_o,
  output logic         bellek_yaz_o,
  output logic [31:0]  bellek_adres_o,
  output logic [31:0]  bellek_veri_o,
  input  logic [31:0]  bellek_veri_i,
  input  logic         bellek_gecerli_i
);

  typedef enum logic [1:0] {BOSTA, AKTAR, TAMAM} durum_t;

  durum_t       r_durum;
  logic [1:0]   r_sayac;
  logic [27:0]  r_taban;
  logic         r_yaz;
  logic [127:0] r_yaz_obek;
  logic [95:0]  r_asm;
  logic [127:0] r_obek;
  logic         r_musait;
  logic         r_hazir;
  logic         r_bellek_istek;
  logic         r_bellek_yaz;
  logic [31:0]  r_bellek_adres;
  logic [31:0]  r_bellek_veri;

  logic [1:0]   w_sonraki;
  logic         w_unused;

  assign w_sonraki = r_sayac + 2'd1;
  // Anything other than a write is serviced as a read, so oku_i carries no decision.
  assign w_unused  = ^{oku_i, adres_i[3:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_durum        <= BOSTA;
      r_sayac        <= 2'd0;
      r_taban        <= 28'd0;
      r_yaz          <= 1'b0;
      r_yaz_obek     <= 128'd0;
      r_asm          <= 96'd0;
      r_obek         <= 128'd0;
      r_musait       <= 1'b0;
      r_hazir        <= 1'b0;
      r_bellek_istek <= 1'b0;
      r_bellek_yaz   <= 1'b0;
      r_bellek_adres <= 32'd0;
      r_bellek_veri  <= 32'd0;
    end else begin
      case (r_durum)
        BOSTA: begin
          // musait_o is held low for the first edge after reset release.
          if (!r_musait) begin
            r_musait <= 1'b1;
          end else if (istek_i) begin
            r_musait       <= 1'b0;
            r_taban        <= adres_i[31:4];
            r_yaz          <= yaz_i;
            r_yaz_obek     <= yaz_obek_i;
            r_sayac        <= 2'd0;
            r_bellek_istek <= 1'b1;
            r_bellek_yaz   <= yaz_i;
            r_bellek_adres <= {adres_i[31:4], 4'b0000};
            r_bellek_veri  <= yaz_obek_i[31:0];
            r_durum        <= AKTAR;
          end
        end
        AKTAR: begin
          if (bellek_gecerli_i) begin
            r_sayac <= w_sonraki;
            if (!r_yaz) begin
              case (r_sayac)
                2'd0:    r_asm[31:0]  <= bellek_veri_i;
                2'd1:    r_asm[63:32] <= bellek_veri_i;
                2'd2:    r_asm[95:64] <= bellek_veri_i;
                default: r_asm        <= r_asm;
              endcase
            end
            if (r_sayac == 2'd3) begin
              r_bellek_istek <= 1'b0;
              r_bellek_yaz   <= 1'b0;
              r_hazir        <= 1'b1;
              r_durum        <= TAMAM;
              if (!r_yaz)
                r_obek <= {bellek_veri_i, r_asm};
            end else begin
              r_bellek_adres <= {r_taban, w_sonraki, 2'b00};
              r_bellek_veri  <= r_yaz_obek[{w_sonraki, 5'b00000} +: 32];
            end
          end
        end
        TAMAM: begin
          r_hazir  <= 1'b0;
          r_musait <= 1'b1;
          r_durum  <= BOSTA;
        end
        default: r_durum <= BOSTA;
      endcase
    end
  end

  assign musait_o       = r_musait;
  assign hazir_o        = r_hazir;
  assign obek_o         = r_obek;
  assign bellek_istek_o = r_bellek_istek;
  assign bellek_yaz_o   = r_bellek_yaz;
  assign bellek_adres_o = r_bellek_adres;
  assign bellek_veri_o  = r_bellek_veri;

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Bench for anabellek_denetleyici: transaction-level model with a per-cycle
// compare process, a wait-state backend and literal pins on key results.
module tb_anabellek_denetleyici;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         istek_i = 1'b0;
  logic         oku_i = 1'b0;
  logic         yaz_i = 1'b0;
  logic [31:0]  adres_i = 32'd0;
  logic [127:0] yaz_obek_i = 128'd0;
  logic         musait_o;
  logic         hazir_o;
  logic [127:0] obek_o;
  logic         bellek_istek_o;
  logic         bellek_yaz_o;
  logic [31:0]  bellek_adres_o;
  logic [31:0]  bellek_veri_o;
  logic [31:0]  bellek_veri_i = 32'd0;
  logic         bellek_gecerli_i = 1'b0;

  anabellek_denetleyici dut (
    .clk_i(clk_i), .rst_i(rst_i), .istek_i(istek_i), .oku_i(oku_i), .yaz_i(yaz_i),
    .adres_i(adres_i), .yaz_obek_i(yaz_obek_i), .musait_o(musait_o), .hazir_o(hazir_o),
    .obek_o(obek_o), .bellek_istek_o(bellek_istek_o), .bellek_yaz_o(bellek_yaz_o),
    .bellek_adres_o(bellek_adres_o), .bellek_veri_o(bellek_veri_o),
    .bellek_veri_i(bellek_veri_i), .bellek_gecerli_i(bellek_gecerli_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  // Transaction model state
  bit           m_active = 1'b0;
  bit           m_rst_hold = 1'b1;
  int           m_acc = 0;
  int           m_w = 0;
  logic [31:0]  m_base = 32'd0;
  bit           m_yaz = 1'b0;
  logic [127:0] m_wdata = 128'd0;
  logic [127:0] m_obek = 128'd0;
  int           hz_edge = 0;
  int           hz_count = 0;

  // Backend state
  int           be_w = 0;
  int           be_cnt = 0;
  logic [31:0]  wq[$];

  localparam logic [127:0] BLK_1000 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] WBLK     = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Memory contents: word k of block at 0x1000 is k+1 repeated; other blocks differ in the top byte.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    logic [31:0] pg;
    k  = {30'd0, a[3:2]};
    pg = (a >> 12) - 32'd1;
    return ((k + 32'd1) * 32'h11111111) ^ (pg << 24);
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] b);
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  // Backend: acknowledges each beat after be_w wait cycles.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      be_cnt = 0;
      bellek_gecerli_i = 1'b0;
    end else if (bellek_istek_o && be_cnt == be_w) begin
      bellek_gecerli_i = 1'b1;
      bellek_veri_i = mem_word(bellek_adres_o);
      be_cnt = 0;
      if (bellek_yaz_o) wq.push_back(bellek_veri_o);
    end else begin
      bellek_gecerli_i = 1'b0;
      if (bellek_istek_o) be_cnt++;
    end
  end

  // Per-cycle compare against the transaction model.
  always @(negedge clk_i) begin : cmp
    int d;
    int per;
    int k;
    if (rst_i) begin
      if (hazir_o === 1'b1) hz_count++;
      if (!m_active) begin
        chk("idle_musait", musait_o, !m_rst_hold);
        chk("idle_hazir", hazir_o, 1'b0);
        chk("idle_istek", bellek_istek_o, 1'b0);
        chk("idle_obek", obek_o, m_obek);
      end else begin
        d = edge_cnt - m_acc;
        per = m_w + 1;
        if (d < 4 * per) begin
          k = d / per;
          chk("beat_musait", musait_o, 1'b0);
          chk("beat_hazir", hazir_o, 1'b0);
          chk("beat_istek", bellek_istek_o, 1'b1);
          chk("beat_adres", bellek_adres_o, m_base + 32'(4 * k));
          chk("beat_yaz", bellek_yaz_o, m_yaz);
          chk("beat_veri", bellek_veri_o, m_wdata[32 * k +: 32]);
          chk("beat_obek", obek_o, m_obek);
        end else if (d == 4 * per) begin
          chk("done_hazir", hazir_o, 1'b1);
          chk("done_musait", musait_o, 1'b0);
          chk("done_istek", bellek_istek_o, 1'b0);
          if (!m_yaz) m_obek = blk(m_base);
          chk("done_obek", obek_o, m_obek);
          hz_edge = edge_cnt;
        end else begin
          chk("post_musait", musait_o, 1'b1);
          chk("post_hazir", hazir_o, 1'b0);
          chk("post_istek", bellek_istek_o, 1'b0);
          chk("post_obek", obek_o, m_obek);
          m_active = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1. hold<0 keeps istek_i high after acceptance.
  task automatic issue(input logic [31:0] a, input bit y, input bit o,
                       input logic [127:0] wd, input int w, input int hold);
    int t;
    t = 0;
    istek_i = 1'b1; adres_i = a; yaz_i = y; oku_i = o; yaz_obek_i = wd; be_w = w;
    while (musait_o !== 1'b1 && t < 100) begin
      @(posedge clk_i); #1; t++;
    end
    if (t >= 100) begin
      bound_fail("accept_wait");
      istek_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    m_active = 1'b1; m_acc = edge_cnt; m_w = w;
    m_base = {a[31:4], 4'b0000}; m_yaz = y; m_wdata = wd;
    $display("txn %s addr=%h waits=%0d accepted at edge %0d", y ? "write" : "read ", a, w, m_acc);
    if (hold >= 0) begin
      repeat (hold) begin @(posedge clk_i); #1; end
      istek_i = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (m_active && t < 200) begin
      @(posedge clk_i); #1; t++;
    end
    if (t >= 200) bound_fail("done_wait");
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : drv
    int acc1;
    int hz0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_musait", musait_o, 1'b0);
    chk("rst_hazir", hazir_o, 1'b0);
    chk("rst_istek", bellek_istek_o, 1'b0);
    chk("rst_yaz", bellek_yaz_o, 1'b0);
    chk("rst_adres", bellek_adres_o, 32'd0);
    chk("rst_veri", bellek_veri_o, 32'd0);
    chk("rst_obek", obek_o, 128'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    m_rst_hold = 1'b0;
    chk("rel_musait", musait_o, 1'b1);

    // Zero-wait read from an unaligned address
    issue(32'h0000_1007, 1'b0, 1'b1, 128'd0, 0, 0);
    wait_done();
    chk("lit_obek_zero", obek_o, BLK_1000);
    chk("lit_lat_zero", 32'(hz_edge - m_acc), 32'd4);

    // Two wait states per beat
    issue(32'h0000_1000, 1'b0, 1'b1, 128'd0, 2, 0);
    wait_done();
    chk("lit_obek_wait", obek_o, BLK_1000);
    chk("lit_lat_wait", 32'(hz_edge - m_acc), 32'd12);

    // Write with both qualifiers set
    wq.delete();
    issue(32'h0000_1000, 1'b1, 1'b1, WBLK, 0, 0);
    wait_done();
    chk("lit_wq_size", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      chk("lit_w0", wq[0], 32'hAAAAAAAA);
      chk("lit_w1", wq[1], 32'hBBBBBBBB);
      chk("lit_w2", wq[2], 32'hCCCCCCCC);
      chk("lit_w3", wq[3], 32'hDDDDDDDD);
    end
    chk("lit_obek_after_write", obek_o, BLK_1000);

    // Request dropped one cycle after acceptance
    hz0 = hz_count;
    issue(32'h0000_2000, 1'b0, 1'b1, 128'd0, 1, 1);
    wait_done();
    chk("lit_drop_pulses", 32'(hz_count - hz0), 32'd1);

    // Back-to-back with istek_i held high
    issue(32'h0000_2000, 1'b0, 1'b1, 128'd0, 0, -1);
    acc1 = m_acc;
    issue(32'h0000_3000, 1'b0, 1'b1, 128'd0, 0, 0);
    chk("lit_b2b_gap", 32'(m_acc - acc1), 32'd6);
    wait_done();
    chk("lit_obek_3000", obek_o[31:0], 32'h13111111);

    // Reset during beat 2
    hz0 = hz_count;
    issue(32'h0000_1000, 1'b0, 1'b1, 128'd0, 0, 0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_active = 1'b0;
    m_obek = 128'd0;
    m_rst_hold = 1'b1;
    #1;
    chk("mid_rst_istek", bellek_istek_o, 1'b0);
    chk("mid_rst_musait", musait_o, 1'b0);
    chk("mid_rst_obek", obek_o, 128'd0);
    repeat (2) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    m_rst_hold = 1'b0;
    chk("mid_rst_rel_musait", musait_o, 1'b1);
    chk("mid_rst_no_hazir", 32'(hz_count - hz0), 32'd0);

    issue(32'h0000_100C, 1'b0, 1'b0, 128'd0, 0, 0);
    wait_done();
    chk("lit_obek_fresh", obek_o, BLK_1000);

    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
